// File: rtl/nibble_serializer.sv
// nibble_serializer: pops nibbles from a FIFO (RE/EMPTY/Q) and shifts them
// out as a gapless bit stream at a programmable bit period.
//
// Ports:
//   CLK, RESET        clock (rising edge), async active-high reset
//   EN                level-sensitive serialiser enable
//   DIV               bit period minus one, in CLK cycles
//   NIB_IN, EMPTY     FIFO read data (pre-pop) and empty flag
//   RE                FIFO read strobe (combinational)
//   BIT_OUT, BIT_STB  serial data and first-cycle-of-bit pulse (registered)
//   BUSY              nibble in flight (registered)
//   UNDERRUN          sticky: stream ran dry while EN=1
//   CLR_UNDERRUN      synchronous clear for UNDERRUN (set wins)
//
// Build option: define NIBBLE_SER_MSB_FIRST_EN to send MSB first
// (default: LSB first). Timing is identical in both builds.

module nibble_serializer #(
    parameter int   NIB_WIDTH  = 4,
    parameter int   DIV_BITS   = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic [DIV_BITS-1:0]  DIV,
    input  logic [NIB_WIDTH-1:0] NIB_IN,
    input  logic                 EMPTY,
    output logic                 RE,
    output logic                 BIT_OUT,
    output logic                 BIT_STB,
    output logic                 BUSY,
    output logic                 UNDERRUN,
    input  logic                 CLR_UNDERRUN
);

    localparam int IW = (NIB_WIDTH > 1) ? $clog2(NIB_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB_WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t               state_q;
    logic [NIB_WIDTH-1:0] shreg_q;
    logic [NIB_WIDTH-1:0] shreg_d;
    logic [DIV_BITS-1:0]  div_q;
    logic [DIV_BITS-1:0]  cnt_q;
    logic [IW-1:0]        idx_q;
    logic                 bit_q;
    logic                 stb_q;
    logic                 busy_q;
    logic                 urun_q;

    logic cnt_done;
    logic last_bit;
    logic end_nib;
    logic set_urun;
    logic first_bit;
    logic next_bit;

    assign cnt_done = (cnt_q == div_q);
    assign last_bit = (idx_q == LAST_IDX);
    assign end_nib  = (state_q == S_SHIFT) && cnt_done && last_bit;
    assign set_urun = end_nib && EN && EMPTY;

    // RESET gates RE so the FIFO is never popped while the block is held.
    assign RE = ~RESET & EN & ~EMPTY & ((state_q == S_IDLE) | end_nib);

    // The shift register keeps the bit on the wire at the output end, so
    // the next bit always sits one position further in.
`ifdef NIBBLE_SER_MSB_FIRST_EN
    assign first_bit = NIB_IN[NIB_WIDTH-1];
    assign next_bit  = shreg_q[NIB_WIDTH-2];
    assign shreg_d   = {shreg_q[NIB_WIDTH-2:0], 1'b0};
`else
    assign first_bit = NIB_IN[0];
    assign next_bit  = shreg_q[1];
    assign shreg_d   = {1'b0, shreg_q[NIB_WIDTH-1:1]};
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            bit_q   <= IDLE_LEVEL;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            stb_q <= 1'b0;

            if (set_urun) begin
                urun_q <= 1'b1;
            end else if (CLR_UNDERRUN) begin
                urun_q <= 1'b0;
            end

            if (RE) begin
                // Load covers both the idle start and the gapless reload.
                state_q <= S_SHIFT;
                shreg_q <= NIB_IN;
                div_q   <= DIV;
                cnt_q   <= '0;
                idx_q   <= '0;
                bit_q   <= first_bit;
                stb_q   <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        bit_q <= IDLE_LEVEL;
                    end
                    S_SHIFT: begin
                        if (cnt_done) begin
                            cnt_q <= '0;
                            if (last_bit) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                bit_q   <= IDLE_LEVEL;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                shreg_q <= shreg_d;
                                bit_q   <= next_bit;
                                stb_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign BIT_OUT  = bit_q;
    assign BIT_STB  = stb_q;
    assign BUSY     = busy_q;
    assign UNDERRUN = urun_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: directed bench for nibble_serializer with a small
// behavioural FIFO that pops on RE.

module tb_nibble_serializer;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic [7:0] DIV;
    logic [3:0] NIB_IN;
    logic       EMPTY;
    logic       RE;
    logic       BIT_OUT;
    logic       BIT_STB;
    logic       BUSY;
    logic       UNDERRUN;
    logic       CLR_UNDERRUN;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] fmem [8];
    int rd_ptr = 0;
    int wr_ptr = 0;

    nibble_serializer #(
        .NIB_WIDTH (4),
        .DIV_BITS  (8),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .EN          (EN),
        .DIV         (DIV),
        .NIB_IN      (NIB_IN),
        .EMPTY       (EMPTY),
        .RE          (RE),
        .BIT_OUT     (BIT_OUT),
        .BIT_STB     (BIT_STB),
        .BUSY        (BUSY),
        .UNDERRUN    (UNDERRUN),
        .CLR_UNDERRUN(CLR_UNDERRUN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (RE) rd_ptr <= rd_ptr + 1;
    end

    assign EMPTY  = (rd_ptr == wr_ptr);
    assign NIB_IN = fmem[rd_ptr % 8];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [3:0] v);
        fmem[wr_ptr % 8] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        EN = 1'b0;
        CLR_UNDERRUN = 1'b0;
        DIV = 8'd0;
        step();
        wr_ptr = rd_ptr;
        step();
        RESET = 1'b0;
    endtask

    function automatic logic nib_bit(input logic [3:0] n, input int k);
`ifdef NIBBLE_SER_MSB_FIRST_EN
        return n[3-k];
`else
        return n[k];
`endif
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        EN = 1'b1;
        CLR_UNDERRUN = 1'b0;
        DIV = 8'd0;
        push(4'hF);
        #3;
        n_tests++;
        if (RE !== 1'b0 || BIT_OUT !== 1'b0 || BIT_STB !== 1'b0 ||
            BUSY !== 1'b0 || UNDERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: re%b bit%b stb%b busy%b ur%b exp 00000",
                     RE, BIT_OUT, BIT_STB, BUSY, UNDERRUN);
        end
        step();
        RESET = 1'b0;
        step();
        step();
        #2;
        n_tests++;
        if (BUSY !== 1'b1 || BIT_STB !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prebusy: busy%b stb%b exp 11",
                     BUSY, BIT_STB);
        end
        RESET = 1'b1;
        push(4'h1);
        #1;
        n_tests++;
        if (RE !== 1'b0 || BIT_OUT !== 1'b0 || BIT_STB !== 1'b0 ||
            BUSY !== 1'b0 || UNDERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: re%b bit%b stb%b busy%b ur%b exp 00000",
                     RE, BIT_OUT, BIT_STB, BUSY, UNDERRUN);
        end
        n_tests++;
        if (EMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo_nonempty: empty=%b exp 0", EMPTY);
        end
    endtask

    task automatic test_gapless();
        logic [9:0] re_e;
        logic [9:0] bit_e;
        logic [9:0] stb_e;
        logic [9:0] ur_e;
        re_e  = 10'b0000010001;
`ifdef NIBBLE_SER_MSB_FIRST_EN
        bit_e = 10'b0110001010;
`else
        bit_e = 10'b0001110100;
`endif
        stb_e = 10'b0111111110;
        ur_e  = 10'b1000000000;
        do_reset();
        DIV = 8'd0;
        push(4'hA);
        push(4'h3);
        EN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++;
            if (RE !== re_e[c]) begin
                n_fail++;
                $display("FAIL gapless_re c%0d: got %b exp %b", c, RE, re_e[c]);
            end
            n_tests++;
            if (BIT_OUT !== bit_e[c]) begin
                n_fail++;
                $display("FAIL gapless_bit c%0d: got %b exp %b",
                         c, BIT_OUT, bit_e[c]);
            end
            n_tests++;
            if (BIT_STB !== stb_e[c] || BUSY !== stb_e[c]) begin
                n_fail++;
                $display("FAIL gapless_stb_busy c%0d: got %b%b exp %b%b",
                         c, BIT_STB, BUSY, stb_e[c], stb_e[c]);
            end
            n_tests++;
            if (UNDERRUN !== ur_e[c]) begin
                n_fail++;
                $display("FAIL gapless_underrun c%0d: got %b exp %b",
                         c, UNDERRUN, ur_e[c]);
            end
            step();
        end
    endtask

    task automatic test_div3();
        int   re_cnt;
        logic be;
        logic se;
        logic ue;
        re_cnt = 0;
        do_reset();
        DIV = 8'd3;
        push(4'h5);
        EN = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (RE === 1'b1) re_cnt++;
            ue = (c >= 1 && c <= 16);
            be = ue ? nib_bit(4'h5, (c - 1) / 4) : 1'b0;
            se = ue && ((c - 1) % 4 == 0);
            n_tests++;
            if (BIT_OUT !== be || BIT_STB !== se || BUSY !== ue) begin
                n_fail++;
                $display("FAIL div3 c%0d: bit/stb/busy %b%b%b exp %b%b%b",
                         c, BIT_OUT, BIT_STB, BUSY, be, se, ue);
            end
            step();
        end
        n_tests++;
        if (re_cnt != 1) begin
            n_fail++;
            $display("FAIL div3_re_count: got %0d exp 1", re_cnt);
        end
        n_tests++;
        if (UNDERRUN !== 1'b1) begin
            n_fail++;
            $display("FAIL div3_underrun: got %b exp 1", UNDERRUN);
        end
    endtask

    task automatic test_en_drop();
        logic be;
        logic ue;
        do_reset();
        DIV = 8'd0;
        push(4'hF);
        push(4'h1);
        EN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) EN = 1'b0;
            #1;
            ue = (c >= 1 && c <= 4);
            be = ue;
            n_tests++;
            if (BIT_OUT !== be || BUSY !== ue || UNDERRUN !== 1'b0) begin
                n_fail++;
                $display("FAIL en_drop c%0d: bit/busy/ur %b%b%b exp %b%b0",
                         c, BIT_OUT, BUSY, UNDERRUN, be, ue);
            end
            if (c >= 1) begin
                n_tests++;
                if (RE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL en_drop_re c%0d: got %b exp 0", c, RE);
                end
            end
            step();
        end
        n_tests++;
        if (EMPTY !== 1'b0 || NIB_IN !== 4'h1) begin
            n_fail++;
            $display("FAIL en_drop_fifo: empty=%b head=%h exp 0/1",
                     EMPTY, NIB_IN);
        end
    endtask

    task automatic test_div_change();
        logic [17:0] re_e;
        logic [17:0] bit_e;
        logic [17:0] stb_e;
        logic [17:0] busy_e;
        re_e   = 18'h00011;
        bit_e  = 18'h03F12;
        stb_e  = 18'h0493E;
        busy_e = 18'h1FFFE;
        do_reset();
        DIV = 8'd0;
        push(4'h9);
        push(4'h6);
        EN = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c == 2) DIV = 8'd2;
            #1;
            n_tests++;
            if (RE !== re_e[c] || BIT_OUT !== bit_e[c] ||
                BIT_STB !== stb_e[c] || BUSY !== busy_e[c]) begin
                n_fail++;
                $display("FAIL div_change c%0d: re/bit/stb/busy %b%b%b%b exp %b%b%b%b",
                         c, RE, BIT_OUT, BIT_STB, BUSY,
                         re_e[c], bit_e[c], stb_e[c], busy_e[c]);
            end
            step();
        end
        n_tests++;
        if (UNDERRUN !== 1'b1) begin
            n_fail++;
            $display("FAIL div_change_underrun: got %b exp 1", UNDERRUN);
        end
        CLR_UNDERRUN = 1'b1;
        step();
        CLR_UNDERRUN = 1'b0;
        n_tests++;
        if (UNDERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clear: got %b exp 0", UNDERRUN);
        end
        DIV = 8'd0;
        push(4'h1);
        repeat (4) step();
        CLR_UNDERRUN = 1'b1;
        step();
        CLR_UNDERRUN = 1'b0;
        n_tests++;
        if (UNDERRUN !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_set_wins: ur/busy %b%b exp 10",
                     UNDERRUN, BUSY);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq8;
        logic       be;
        logic       se;
        do_reset();
        DIV = 8'd1;
        push(4'hF);
        EN = 1'b1;
        repeat (5) step();
        #1;
        n_tests++;
        if (BIT_OUT !== 1'b1 || BIT_STB !== 1'b1 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: bit/stb/busy %b%b%b exp 111",
                     BIT_OUT, BIT_STB, BUSY);
        end
        RESET = 1'b1;
        push(4'h6);
        #1;
        n_tests++;
        if (RE !== 1'b0 || BIT_OUT !== 1'b0 || BIT_STB !== 1'b0 ||
            BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: re/bit/stb/busy %b%b%b%b exp 0000",
                     RE, BIT_OUT, BIT_STB, BUSY);
        end
        step();
        RESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            be = (c >= 3 && c <= 6);
            se = (c == 1 || c == 3 || c == 5 || c == 7);
            n_tests++;
            if (BIT_OUT !== be || BIT_STB !== se) begin
                n_fail++;
                $display("FAIL restart_0x6 c%0d: bit/stb %b%b exp %b%b",
                         c, BIT_OUT, BIT_STB, be, se);
            end
            step();
        end
`ifdef NIBBLE_SER_MSB_FIRST_EN
        seq8 = 4'b0001;
`else
        seq8 = 4'b1000;
`endif
        DIV = 8'd0;
        push(4'h8);
        for (int c = 0; c < 6; c++) begin
            #1;
            be = (c >= 1 && c <= 4) ? seq8[(c >= 1) ? c - 1 : 0] : 1'b0;
            n_tests++;
            if (BIT_OUT !== be) begin
                n_fail++;
                $display("FAIL order_0x8 c%0d: got %b exp %b", c, BIT_OUT, be);
            end
            step();
        end
    endtask

    initial begin
        RESET = 1'b1;
        EN = 1'b0;
        DIV = 8'd0;
        CLR_UNDERRUN = 1'b0;
        test_reset();
        test_gapless();
        test_div3();
        test_en_drop();
        test_div_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
